// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b, one bit per clock, LSB first,
// through a single full-subtractor cell and a registered borrow bit.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | shifting operands through the full-subtractor cell
// DONE  | result published, done pulsed; start here launches the next operation
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a_msb;
  logic             b_msb;

  logic x, y, d, br_nxt;

  assign x      = sa[0];
  assign y      = sb[0];
  assign d      = x ^ y ^ br;
  assign br_nxt = (~x & y) | (~(x ^ y) & br);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nxt;
          res <= {d, res[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          // Last bit: publish the completed word directly, so diff never shows partial shifts.
          if (cnt == LAST) begin
            diff       <= {d, res[WIDTH-1:1]};
            borrow_out <= br_nxt;
            overflow   <= (a_msb ^ b_msb) & (d ^ a_msb);
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: expected results are queued at launch
// and compared by a monitor whenever done pulses.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow_out, overflow;
  logic [W-1:0] diff;

  typedef struct {
    logic [W-1:0] diff;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic done_prev = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff),
    .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   sd;
    sd   = $signed(av) - $signed(bv);
    e.diff = W'(int'(av) - int'(bv));
    e.bo   = (int'(av) < int'(bv));
    e.ov   = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    return e;
  endfunction

  // Monitor: compare every done pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("diff", 32'(diff), 32'(e.diff));
        chk("borrow_out", 32'(borrow_out), 32'(e.bo));
        chk("overflow", 32'(overflow), 32'(e.ov));
      end
    end
    if (busy && done) chk("busy_done_overlap", 32'd1, 32'd0);
    if (done && done_prev) chk("done_width", 32'd2, 32'd1);
    done_prev = done;
  end

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    int lat;
    int busy_cyc;
    exp_q.push_back(model(av, bv));
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~av; b = ~bv;
    chk("busy_e0", 32'(busy), 32'd1);
    lat = -1;
    busy_cyc = 1;
    for (int k = 1; k <= W + 2; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
      if (busy) busy_cyc++;
    end
    chk("latency", 32'(lat), 32'(W));
    chk("busy_cycles", 32'(busy_cyc), 32'(W));
    @(posedge clk); #1;
    chk("done_cleared", 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #23;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd9, 4'd3);
    run_op(4'd3, 4'd9);
    run_op(4'd8, 4'd1);
    run_op(4'd0, 4'd0);
    run_op(4'd7, 4'd8);
    run_op(4'd15, 4'd0);
    for (int i = 0; i < 6; i++)
      run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));

    // Start during RUN is ignored; start in the DONE cycle chains a new op.
    exp_q.push_back(model(4'd5, 4'd2));
    @(negedge clk);
    a = 4'd5; b = 4'd2; start = 1'b1;
    @(posedge clk); #1;                       // E0
    start = 1'b0;
    @(posedge clk);                           // E1
    @(negedge clk);
    a = 4'd15; b = 4'd15; start = 1'b1;
    @(posedge clk); #1;                       // E2
    start = 1'b0;
    chk("ignore_busy_e2", 32'(busy), 32'd1);
    @(posedge clk); #1;                       // E3
    chk("ignore_no_done_e3", 32'(done), 32'd0);
    @(posedge clk); #1;                       // E4
    chk("ignore_done_e4", 32'(done), 32'd1);
    exp_q.push_back(model(4'd1, 4'd2));
    a = 4'd1; b = 4'd2; start = 1'b1;
    @(posedge clk); #1;                       // E5
    start = 1'b0;
    chk("chain_busy_e5", 32'(busy), 32'd1);
    chk("chain_done_e5", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;                                       // E8
    chk("chain_no_done_e8", 32'(done), 32'd0);
    @(posedge clk); #1;                       // E9
    chk("chain_done_e9", 32'(done), 32'd1);
    chk("chain_diff_e9", 32'(diff), 32'hF);
    @(posedge clk); #1;

    // Asynchronous reset mid-operation discards the op (no expectation queued).
    @(negedge clk);
    a = 4'd9; b = 4'd3; start = 1'b1;
    @(posedge clk); #1;                       // E0
    start = 1'b0;
    @(posedge clk); #3;                       // between E1 and E2
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_diff", 32'(diff), 32'd0);
    chk("arst_borrow", 32'(borrow_out), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(posedge clk);
    #1;
    chk("arst_still_idle", 32'(busy), 32'd0);
    run_op(4'd9, 4'd3);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
